hazard_ctrl: RTL and testbench

Parametrised pipeline hazard, forwarding and memory-wait controller for the five-stage MIPS core. Replaces the stall-only hazard logic in the top level: in forwarding mode it stalls only on load-use, drives EX-stage forwarding and ID-stage write-back bypass selects, and freezes the pipeline while a variable-latency data memory is not ready. It also keeps saturating stall, flush and wait counters and a sticky memory-timeout error.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand-source selects and wait FSM states.
// No logic here; types and constants only.
// No flow control of its own.
package hazard_pkg;

    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mstate_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline statistics.
// Count updates one cycle after inc; holds at all-ones instead of wrapping.
// Never stalls; inc is sampled every cycle.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory-wait controller for the five-stage pipeline.
// Selects/enables/flushes are combinational (zero latency); busy, error and counters are registered.
// A memory not ready freezes every stage and bubbles MEM/WB until ready or timeout.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W        = 5,
    parameter int CNT_W       = 32,
    parameter int FORWARDING  = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jump,
    input  logic [RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [RA_W-1:0]  ex_write_reg,
    input  logic             mem_reg_write,
    input  logic [RA_W-1:0]  mem_write_reg,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             mem_branch_taken,
    input  logic             wb_reg_write,
    input  logic [RA_W-1:0]  wb_write_reg,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic             jump_allow,
    output logic             mem_busy,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int TC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    // A producer only counts if it writes a non-zero register the consumer actually reads.
    function automatic logic hit(input logic wr, input logic [RA_W-1:0] dst,
                                 input logic [RA_W-1:0] src, input logic use_src);
        return wr && (dst != '0) && (dst == src) && use_src;
    endfunction

    logic ex_hit_id, mem_hit_id, wb_hit_id;
    logic lu_stall, mwait;
    logic stall_inc, flush_inc;

    mstate_t         state;
    logic [TC_W-1:0] tcnt;

    assign ex_hit_id  = hit(ex_reg_write,  ex_write_reg,  id_rs, id_use_rs)
                      | hit(ex_reg_write,  ex_write_reg,  id_rt, id_use_rt);
    assign mem_hit_id = hit(mem_reg_write, mem_write_reg, id_rs, id_use_rs)
                      | hit(mem_reg_write, mem_write_reg, id_rt, id_use_rt);
    assign wb_hit_id  = hit(wb_reg_write,  wb_write_reg,  id_rs, id_use_rs)
                      | hit(wb_reg_write,  wb_write_reg,  id_rt, id_use_rt);

    assign lu_stall = (FORWARDING != 0) ? (ex_mem_read & ex_hit_id)
                                        : (ex_hit_id | mem_hit_id | wb_hit_id);

    // Once the timeout has fired the pipeline is let go; loaded data is garbage from then on.
    assign mwait = mem_access & ~mem_ready & ~mem_error;

    always_comb begin
        fwd_a    = FWD_IDEX;
        fwd_b    = FWD_IDEX;
        id_byp_a = 1'b0;
        id_byp_b = 1'b0;
        if (FORWARDING != 0) begin
            if (hit(mem_reg_write, mem_write_reg, ex_rs, 1'b1))
                fwd_a = FWD_MEM;
            else if (hit(wb_reg_write, wb_write_reg, ex_rs, 1'b1))
                fwd_a = FWD_WB;

            if (hit(mem_reg_write, mem_write_reg, ex_rt, 1'b1))
                fwd_b = FWD_MEM;
            else if (hit(wb_reg_write, wb_write_reg, ex_rt, 1'b1))
                fwd_b = FWD_WB;

            id_byp_a = hit(wb_reg_write, wb_write_reg, id_rs, id_use_rs);
            id_byp_b = hit(wb_reg_write, wb_write_reg, id_rt, id_use_rt);
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        jump_allow    = 1'b0;
        if (mwait) begin
            // Branch/jump requests stay parked in their stage registers until the wait ends.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (lu_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            if_id_flush = id_jump;
            jump_allow  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            mem_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mwait) begin
                        state <= ST_WAIT;
                        tcnt  <= TC_W'(1);
                    end
                end
                ST_WAIT: begin
                    // Ready on the timeout cycle wins: the access completed, no error.
                    if (mem_ready) begin
                        state <= ST_IDLE;
                    end else if (tcnt == TC_W'(MEM_TIMEOUT)) begin
                        state     <= ST_IDLE;
                        mem_error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_busy = (state == ST_WAIT);

    assign stall_inc = lu_stall & ~mwait & ~mem_branch_taken;
    assign flush_inc = mem_branch_taken & ~mwait;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mwait),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default, legacy (no forwarding) and small (timeout 4, 3-bit counters) instances share stimulus.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic       id_use_rs, id_use_rt, id_jump, ex_reg_write, ex_mem_read;
    logic       mem_reg_write, mem_access, mem_ready, mem_branch_taken, wb_reg_write;

    logic [1:0]  d_fwd_a, d_fwd_b, l_fwd_a, l_fwd_b, s_fwd_a, s_fwd_b;
    logic        d_byp_a, d_byp_b, l_byp_a, l_byp_b, s_byp_a, s_byp_b;
    logic        d_pc_en, d_if_id_en, d_id_ex_en, d_ex_mem_en;
    logic        l_pc_en, l_if_id_en, l_id_ex_en, l_ex_mem_en;
    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en;
    logic        d_if_id_flush, d_id_ex_flush, d_ex_mem_flush, d_bubble, d_jump_allow;
    logic        l_if_id_flush, l_id_ex_flush, l_ex_mem_flush, l_bubble, l_jump_allow;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_bubble, s_jump_allow;
    logic        d_mem_busy, d_mem_error, l_mem_busy, l_mem_error, s_mem_busy, s_mem_error;
    logic [31:0] d_stall_cnt, d_flush_cnt, d_wait_cnt, l_stall_cnt, l_flush_cnt, l_wait_cnt;
    logic [2:0]  s_stall_cnt, s_flush_cnt, s_wait_cnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .mem_access(mem_access), .mem_ready(mem_ready), .mem_branch_taken(mem_branch_taken),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .fwd_a(d_fwd_a), .fwd_b(d_fwd_b), .id_byp_a(d_byp_a), .id_byp_b(d_byp_b),
        .pc_en(d_pc_en), .if_id_en(d_if_id_en), .id_ex_en(d_id_ex_en), .ex_mem_en(d_ex_mem_en),
        .if_id_flush(d_if_id_flush), .id_ex_flush(d_id_ex_flush), .ex_mem_flush(d_ex_mem_flush),
        .mem_wb_bubble(d_bubble), .jump_allow(d_jump_allow), .mem_busy(d_mem_busy), .mem_error(d_mem_error),
        .stall_cnt(d_stall_cnt), .flush_cnt(d_flush_cnt), .wait_cnt(d_wait_cnt)
    );

    hazard_ctrl #(.FORWARDING(0)) dut_leg (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .mem_access(mem_access), .mem_ready(mem_ready), .mem_branch_taken(mem_branch_taken),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .fwd_a(l_fwd_a), .fwd_b(l_fwd_b), .id_byp_a(l_byp_a), .id_byp_b(l_byp_b),
        .pc_en(l_pc_en), .if_id_en(l_if_id_en), .id_ex_en(l_id_ex_en), .ex_mem_en(l_ex_mem_en),
        .if_id_flush(l_if_id_flush), .id_ex_flush(l_id_ex_flush), .ex_mem_flush(l_ex_mem_flush),
        .mem_wb_bubble(l_bubble), .jump_allow(l_jump_allow), .mem_busy(l_mem_busy), .mem_error(l_mem_error),
        .stall_cnt(l_stall_cnt), .flush_cnt(l_flush_cnt), .wait_cnt(l_wait_cnt)
    );

    hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_small (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .mem_access(mem_access), .mem_ready(mem_ready), .mem_branch_taken(mem_branch_taken),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .id_byp_a(s_byp_a), .id_byp_b(s_byp_b),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
        .mem_wb_bubble(s_bubble), .jump_allow(s_jump_allow), .mem_busy(s_mem_busy), .mem_error(s_mem_error),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .wait_cnt(s_wait_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0;
        ex_write_reg = 0; mem_write_reg = 0; wb_write_reg = 0;
        id_use_rs = 0; id_use_rt = 0; id_jump = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_reg_write = 0; mem_access = 0; mem_ready = 0; mem_branch_taken = 0; wb_reg_write = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic load_use_inputs();
        ex_reg_write = 1; ex_mem_read = 1; ex_write_reg = 5; id_rt = 5; id_use_rt = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (d_stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", d_stall_cnt); end
        n_vec++; if (d_flush_cnt !== 32'd0) begin n_err++; $display("FAIL rst_flush_cnt: got %0d want 0", d_flush_cnt); end
        n_vec++; if (d_wait_cnt !== 32'd0) begin n_err++; $display("FAIL rst_wait_cnt: got %0d want 0", d_wait_cnt); end
        n_vec++; if (d_mem_busy !== 1'b0) begin n_err++; $display("FAIL rst_mem_busy: got %b want 0", d_mem_busy); end
        n_vec++; if (d_mem_error !== 1'b0) begin n_err++; $display("FAIL rst_mem_error: got %b want 0", d_mem_error); end
        n_vec++; if ({d_pc_en, d_if_id_en, d_id_ex_en, d_ex_mem_en} !== 4'b1111) begin n_err++; $display("FAIL rst_enables: got %b want 1111", {d_pc_en, d_if_id_en, d_id_ex_en, d_ex_mem_en}); end
        n_vec++; if ({d_if_id_flush, d_id_ex_flush, d_ex_mem_flush, d_bubble} !== 4'b0000) begin n_err++; $display("FAIL rst_flushes: got %b want 0000", {d_if_id_flush, d_id_ex_flush, d_ex_mem_flush, d_bubble}); end
        n_vec++; if ({d_fwd_a, d_fwd_b} !== 4'b0000) begin n_err++; $display("FAIL rst_fwd: got %b want 0000", {d_fwd_a, d_fwd_b}); end
        n_vec++; if (d_jump_allow !== 1'b1) begin n_err++; $display("FAIL rst_jump_allow: got %b want 1", d_jump_allow); end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_forward();
        do_reset();
        ex_reg_write = 1; ex_write_reg = 3; mem_reg_write = 1; mem_write_reg = 3;
        wb_reg_write = 1; wb_write_reg = 3; ex_rs = 3; ex_rt = 7;
        #1;
        n_vec++; if (d_fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_mem_prio: got %b want 10", d_fwd_a); end
        n_vec++; if (d_fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_b_nomatch: got %b want 00", d_fwd_b); end
        n_vec++; if (l_fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_legacy_zero: got %b want 00", l_fwd_a); end
        mem_reg_write = 0; ex_rt = 3;
        #1;
        n_vec++; if (d_fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_wb: got %b want 01", d_fwd_a); end
        n_vec++; if (d_fwd_b !== 2'b01) begin n_err++; $display("FAIL fwd_b_wb: got %b want 01", d_fwd_b); end
        mem_reg_write = 1; mem_write_reg = 0; wb_write_reg = 0;
        #1;
        n_vec++; if (d_fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_reg0: got %b want 00", d_fwd_a); end
        wb_write_reg = 9; id_rs = 9; id_use_rs = 1;
        #1;
        n_vec++; if (d_byp_a !== 1'b1) begin n_err++; $display("FAIL byp_a: got %b want 1", d_byp_a); end
        n_vec++; if (d_byp_b !== 1'b0) begin n_err++; $display("FAIL byp_b_idle: got %b want 0", d_byp_b); end
        n_vec++; if (d_pc_en !== 1'b1) begin n_err++; $display("FAIL byp_no_stall: got %b want 1", d_pc_en); end
        n_vec++; if (l_pc_en !== 1'b0) begin n_err++; $display("FAIL legacy_wb_stall: got %b want 0", l_pc_en); end
        id_use_rs = 0;
        #1;
        n_vec++; if (d_byp_a !== 1'b0) begin n_err++; $display("FAIL byp_unused_src: got %b want 0", d_byp_a); end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use_inputs();
        #1;
        n_vec++; if ({d_pc_en, d_if_id_en} !== 2'b00) begin n_err++; $display("FAIL lu_enables: got %b want 00", {d_pc_en, d_if_id_en}); end
        n_vec++; if (d_id_ex_flush !== 1'b1) begin n_err++; $display("FAIL lu_id_ex_flush: got %b want 1", d_id_ex_flush); end
        n_vec++; if ({d_id_ex_en, d_ex_mem_en, d_jump_allow} !== 3'b110) begin n_err++; $display("FAIL lu_other: got %b want 110", {d_id_ex_en, d_ex_mem_en, d_jump_allow}); end
        n_vec++; if (d_stall_cnt !== 32'd0) begin n_err++; $display("FAIL lu_cnt_before: got %0d want 0", d_stall_cnt); end
        tick();
        n_vec++; if (d_stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt_after: got %0d want 1", d_stall_cnt); end
        ex_mem_read = 0;
        #1;
        n_vec++; if (d_pc_en !== 1'b1) begin n_err++; $display("FAIL lu_alu_fwd_no_stall: got %b want 1", d_pc_en); end
        n_vec++; if ({l_pc_en, l_if_id_en, l_id_ex_flush} !== 3'b001) begin n_err++; $display("FAIL legacy_stall: got %b want 001", {l_pc_en, l_if_id_en, l_id_ex_flush}); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_access = 1; mem_ready = 0; id_jump = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if ({d_pc_en, d_if_id_en, d_id_ex_en, d_ex_mem_en, d_bubble} !== 5'b00001) begin n_err++; $display("FAIL wait_freeze[%0d]: got %b want 00001", i, {d_pc_en, d_if_id_en, d_id_ex_en, d_ex_mem_en, d_bubble}); end
            n_vec++; if ({d_if_id_flush, d_jump_allow} !== 2'b00) begin n_err++; $display("FAIL wait_jump_held[%0d]: got %b want 00", i, {d_if_id_flush, d_jump_allow}); end
            n_vec++; if (d_mem_busy !== (i > 0)) begin n_err++; $display("FAIL wait_busy[%0d]: got %b want %b", i, d_mem_busy, (i > 0)); end
            tick();
        end
        mem_ready = 1;
        #1;
        n_vec++; if (d_mem_busy !== 1'b1) begin n_err++; $display("FAIL ready_busy: got %b want 1", d_mem_busy); end
        n_vec++; if ({d_pc_en, d_bubble, d_if_id_flush, d_jump_allow} !== 4'b1011) begin n_err++; $display("FAIL ready_release: got %b want 1011", {d_pc_en, d_bubble, d_if_id_flush, d_jump_allow}); end
        tick();
        n_vec++; if (d_mem_busy !== 1'b0) begin n_err++; $display("FAIL ready_idle: got %b want 0", d_mem_busy); end
        n_vec++; if (d_wait_cnt !== 32'd3) begin n_err++; $display("FAIL wait_cnt: got %0d want 3", d_wait_cnt); end
        n_vec++; if ({d_mem_error, s_mem_error} !== 2'b00) begin n_err++; $display("FAIL wait_no_error: got %b want 00", {d_mem_error, s_mem_error}); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_access = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++; if ({s_mem_busy, s_mem_error} !== 2'b10) begin n_err++; $display("FAIL to_waiting[%0d]: got %b want 10", i, {s_mem_busy, s_mem_error}); end
        end
        tick();
        n_vec++; if ({s_mem_busy, s_mem_error} !== 2'b01) begin n_err++; $display("FAIL to_error: got %b want 01", {s_mem_busy, s_mem_error}); end
        n_vec++; if ({s_pc_en, s_ex_mem_en, s_bubble} !== 3'b110) begin n_err++; $display("FAIL to_resume: got %b want 110", {s_pc_en, s_ex_mem_en, s_bubble}); end
        n_vec++; if (s_wait_cnt !== 3'd5) begin n_err++; $display("FAIL to_wait_cnt: got %0d want 5", s_wait_cnt); end
        n_vec++; if ({d_mem_busy, d_mem_error} !== 2'b10) begin n_err++; $display("FAIL to_long_still_wait: got %b want 10", {d_mem_busy, d_mem_error}); end
        tick();
        n_vec++; if ({s_mem_error, s_mem_busy} !== 2'b10) begin n_err++; $display("FAIL to_sticky: got %b want 10", {s_mem_error, s_mem_busy}); end
        n_vec++; if (s_wait_cnt !== 3'd5) begin n_err++; $display("FAIL to_wait_cnt_hold: got %0d want 5", s_wait_cnt); end
        reset = 1;
        tick();
        n_vec++; if (s_mem_error !== 1'b0) begin n_err++; $display("FAIL to_reset_clear: got %b want 0", s_mem_error); end
        n_vec++; if (d_mem_busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_wait: got %b want 0", d_mem_busy); end
        idle_inputs();
        reset = 0;
        #1;
    endtask

    task automatic test_priority();
        do_reset();
        load_use_inputs();
        mem_branch_taken = 1;
        #1;
        n_vec++; if ({d_if_id_flush, d_id_ex_flush, d_ex_mem_flush, d_jump_allow} !== 4'b1110) begin n_err++; $display("FAIL br_flushes: got %b want 1110", {d_if_id_flush, d_id_ex_flush, d_ex_mem_flush, d_jump_allow}); end
        n_vec++; if ({d_pc_en, d_if_id_en, d_id_ex_en, d_ex_mem_en} !== 4'b1111) begin n_err++; $display("FAIL br_enables: got %b want 1111", {d_pc_en, d_if_id_en, d_id_ex_en, d_ex_mem_en}); end
        tick();
        n_vec++; if (d_flush_cnt !== 32'd1) begin n_err++; $display("FAIL br_flush_cnt: got %0d want 1", d_flush_cnt); end
        n_vec++; if (d_stall_cnt !== 32'd0) begin n_err++; $display("FAIL br_stall_cnt: got %0d want 0", d_stall_cnt); end
        mem_access = 1; mem_ready = 0;
        #1;
        n_vec++; if ({d_if_id_flush, d_id_ex_flush, d_ex_mem_flush, d_pc_en, d_bubble} !== 5'b00001) begin n_err++; $display("FAIL freeze_wins: got %b want 00001", {d_if_id_flush, d_id_ex_flush, d_ex_mem_flush, d_pc_en, d_bubble}); end
        tick();
        n_vec++; if ({d_flush_cnt, d_stall_cnt, d_wait_cnt} !== {32'd1, 32'd0, 32'd1}) begin n_err++; $display("FAIL freeze_cnts: got %0d/%0d/%0d want 1/0/1", d_flush_cnt, d_stall_cnt, d_wait_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        load_use_inputs();
        repeat (10) tick();
        n_vec++; if (s_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_small: got %0d want 7", s_stall_cnt); end
        n_vec++; if (d_stall_cnt !== 32'd10) begin n_err++; $display("FAIL sat_wide: got %0d want 10", d_stall_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
